// File: rtl/difftest_commit_batcher.sv
// rtl/difftest_commit_batcher.sv - multi-lane commit record batcher feeding the difftest bridge
module difftest_commit_batcher #(
   parameter int NUM_PORTS = 4,
   parameter int DEPTH     = 16,
   parameter int LW        = $clog2(NUM_PORTS),
   parameter int CW        = $clog2(DEPTH + 1)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [NUM_PORTS-1:0]     io_valid,
   input  logic [NUM_PORTS-1:0]     io_skip,
   input  logic [NUM_PORTS-1:0]     io_isRVC,
   input  logic [NUM_PORTS-1:0]     io_rfwen,
   input  logic [8*NUM_PORTS-1:0]   io_wdest,
   input  logic [64*NUM_PORTS-1:0]  io_pc,
   input  logic [32*NUM_PORTS-1:0]  io_instr,
   input  logic [10*NUM_PORTS-1:0]  io_robIdx,
   input  logic [7:0]               io_coreid,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LW-1:0]            out_lane,
   output logic                     out_skip,
   output logic                     out_isRVC,
   output logic                     out_rfwen,
   output logic [7:0]               out_wdest,
   output logic [63:0]              out_pc,
   output logic [31:0]              out_instr,
   output logic [9:0]               out_robIdx,
   output logic [7:0]               out_coreid,
   output logic [31:0]              out_seq,
   output logic                     stall,
   output logic                     overflow,
   output logic [15:0]              drop_cnt,
   output logic [CW-1:0]            count
);

   localparam int AW = $clog2(DEPTH);
   localparam int NW = LW + 1;
   localparam int RW = LW + 3 + 8 + 64 + 32 + 10 + 8;

   // Record layout: {lane, skip, isRVC, rfwen, wdest, pc, instr, robIdx, coreid}
   logic [RW-1:0] mem [DEPTH];

   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count_q;
   logic [31:0]   seq_q;
   logic          overflow_q;
   logic [15:0]   drop_q;

   logic [NW-1:0] n;
   logic [NW-1:0] lane_off [NUM_PORTS];
   logic [RW-1:0] lane_rec [NUM_PORTS];
   logic [CW-1:0] free_slots;
   logic          accept;
   logic          drop;
   logic          deq;
   logic [16:0]   drop_sum;
   logic [15:0]   drop_next;

   // Prefix popcount: each valid lane's slot offset from wr_ptr, and the group size
   always_comb begin
      n = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         lane_off[i] = n;
         if (enable && io_valid[i]) begin
            n = n + NW'(1);
         end
      end
   end

   // Slice the flat lane buses into per-lane packed records
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         lane_rec[i] = {LW'(i), io_skip[i], io_isRVC[i], io_rfwen[i],
                        io_wdest[8*i +: 8], io_pc[64*i +: 64],
                        io_instr[32*i +: 32], io_robIdx[10*i +: 10], io_coreid};
      end
   end

   // Space is judged on registered occupancy only; a same-cycle pop never makes room
   assign free_slots = CW'(DEPTH) - count_q;
   assign accept     = (n != '0) && (CW'(n) <= free_slots);
   assign drop       = (n != '0) && !accept;
   assign out_valid  = (count_q != '0);
   assign deq        = out_valid && out_ready;
   assign stall      = free_slots < CW'(2 * NUM_PORTS);

   assign drop_sum   = {1'b0, drop_q} + 17'(n);
   assign drop_next  = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

   // Write the compacted group into consecutive slots starting at wr_ptr
   always_ff @(posedge clock) begin
      if (accept) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (io_valid[i]) begin
               mem[wr_ptr + AW'(lane_off[i])] <= lane_rec[i];
            end
         end
      end
   end

   // Pointers, occupancy, sequence number and drop statistics
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count_q    <= '0;
         seq_q      <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + AW'(n);
         end
         if (deq) begin
            rd_ptr <= rd_ptr + AW'(1);
            seq_q  <= seq_q + 32'd1;
         end
         count_q <= count_q + (accept ? CW'(n) : CW'(0)) - (deq ? CW'(1) : CW'(0));
         if (drop) begin
            overflow_q <= 1'b1;
            drop_q     <= drop_next;
         end
      end
   end

   assign {out_lane, out_skip, out_isRVC, out_rfwen, out_wdest,
           out_pc, out_instr, out_robIdx, out_coreid} = mem[rd_ptr];
   assign out_seq  = seq_q;
   assign overflow = overflow_q;
   assign drop_cnt = drop_q;
   assign count    = count_q;

endmodule

// File: tb/tb_difftest_commit_batcher.sv
// tb/tb_difftest_commit_batcher.sv - directed self-checking bench for difftest_commit_batcher
module tb_difftest_commit_batcher;

   localparam int NP = 4;
   localparam int D  = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic          enable;
   logic [3:0]    io_valid;
   logic [3:0]    io_skip;
   logic [3:0]    io_isRVC;
   logic [3:0]    io_rfwen;
   logic [31:0]   io_wdest;
   logic [255:0]  io_pc;
   logic [127:0]  io_instr;
   logic [39:0]   io_robIdx;
   logic [7:0]    io_coreid;
   logic          out_valid;
   logic          out_ready;
   logic [1:0]    out_lane;
   logic          out_skip;
   logic          out_isRVC;
   logic          out_rfwen;
   logic [7:0]    out_wdest;
   logic [63:0]   out_pc;
   logic [31:0]   out_instr;
   logic [9:0]    out_robIdx;
   logic [7:0]    out_coreid;
   logic [31:0]   out_seq;
   logic          stall;
   logic          overflow;
   logic [15:0]   drop_cnt;
   logic [4:0]    count;

   int n_pass  = 0;
   int n_total = 0;

   difftest_commit_batcher #(.NUM_PORTS(NP), .DEPTH(D)) dut (
      .clock(clock), .reset(reset), .enable(enable),
      .io_valid(io_valid), .io_skip(io_skip), .io_isRVC(io_isRVC), .io_rfwen(io_rfwen),
      .io_wdest(io_wdest), .io_pc(io_pc), .io_instr(io_instr), .io_robIdx(io_robIdx),
      .io_coreid(io_coreid), .out_valid(out_valid), .out_ready(out_ready),
      .out_lane(out_lane), .out_skip(out_skip), .out_isRVC(out_isRVC), .out_rfwen(out_rfwen),
      .out_wdest(out_wdest), .out_pc(out_pc), .out_instr(out_instr), .out_robIdx(out_robIdx),
      .out_coreid(out_coreid), .out_seq(out_seq), .stall(stall), .overflow(overflow),
      .drop_cnt(drop_cnt), .count(count)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Lane i of tag T carries pc {T, i}, wdest 0x10+i, instr 0x13000000+i, robIdx 0x100+i
   task automatic drive(input logic [3:0] v, input logic [31:0] tag);
      io_valid = v;
      for (int i = 0; i < NP; i++) begin
         io_skip[i]              = i[0];
         io_isRVC[i]             = i[1];
         io_rfwen[i]             = 1'b1;
         io_wdest[8*i +: 8]      = 8'h10 + 8'(i);
         io_pc[64*i +: 64]       = {tag, 32'(i)};
         io_instr[32*i +: 32]    = 32'h1300_0000 + 32'(i);
         io_robIdx[10*i +: 10]   = 10'h100 + 10'(i);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1; out_ready = 1'b0; io_coreid = 8'h5A;
      drive(4'b0000, 32'h0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      n_total++; if (count !== 5'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
      n_total++; if (stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall); else n_pass++;
      n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b exp 0", overflow); else n_pass++;
      n_total++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop_cnt got %0d exp 0", drop_cnt); else n_pass++;
      n_total++; if (out_seq !== 32'd0) $display("FAIL reset_out_seq got %0d exp 0", out_seq); else n_pass++;
   endtask

   task automatic test_sparse_group();
      out_ready = 1'b1;
      drive(4'b1011, 32'h11);
      @(negedge clock);
      drive(4'b0000, 32'h0);
      n_total++; if (count !== 5'd3) $display("FAIL sparse_count_peak got %0d exp 3", count); else n_pass++;
      n_total++; if ({out_valid, out_lane, out_seq} !== {1'b1, 2'd0, 32'd0})
         $display("FAIL sparse_beat0 got v=%b lane=%0d seq=%0d exp v=1 lane=0 seq=0", out_valid, out_lane, out_seq); else n_pass++;
      @(negedge clock);
      n_total++; if ({out_lane, out_seq, count} !== {2'd1, 32'd1, 5'd2})
         $display("FAIL sparse_beat1 got lane=%0d seq=%0d count=%0d exp lane=1 seq=1 count=2", out_lane, out_seq, count); else n_pass++;
      @(negedge clock);
      n_total++; if ({out_lane, out_seq, count} !== {2'd3, 32'd2, 5'd1})
         $display("FAIL sparse_beat2 got lane=%0d seq=%0d count=%0d exp lane=3 seq=2 count=1", out_lane, out_seq, count); else n_pass++;
      n_total++; if ({out_skip, out_isRVC, out_rfwen, out_wdest, out_pc, out_instr, out_robIdx, out_coreid} !==
                     {1'b1, 1'b1, 1'b1, 8'h13, 32'h11, 32'd3, 32'h1300_0003, 10'h103, 8'h5A})
         $display("FAIL sparse_lane3_fields got wdest=%h pc=%h instr=%h rob=%h core=%h", out_wdest, out_pc, out_instr, out_robIdx, out_coreid); else n_pass++;
      @(negedge clock);
      n_total++; if ({out_valid, count} !== {1'b0, 5'd0})
         $display("FAIL sparse_drained got v=%b count=%0d exp v=0 count=0", out_valid, count); else n_pass++;
   endtask

   task automatic test_fill_and_drain();
      out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         drive(4'b1111, 32'h200 + 32'(c));
         @(negedge clock);
         n_total++; if ({count, stall} !== {5'(4 * (c + 1)), (c >= 2)})
            $display("FAIL fill_step%0d got count=%0d stall=%b exp count=%0d stall=%b", c, count, stall, 4 * (c + 1), c >= 2); else n_pass++;
      end
      drive(4'b0000, 32'h0);
      @(negedge clock);
      n_total++; if ({count, drop_cnt, overflow} !== {5'd16, 16'd0, 1'b0})
         $display("FAIL fill_full got count=%0d drop=%0d ovf=%b exp 16 0 0", count, drop_cnt, overflow); else n_pass++;
      n_total++; if ({out_pc, out_lane, out_seq} !== {32'h200, 32'd0, 2'd0, 32'd3})
         $display("FAIL fill_head_hold got pc=%h lane=%0d seq=%0d", out_pc, out_lane, out_seq); else n_pass++;
      out_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         n_total++; if ({out_valid, out_lane, out_pc, out_seq} !== {1'b1, 2'(k % 4), 32'h200 + 32'(k / 4), 32'(k % 4), 32'd3 + 32'(k)})
            $display("FAIL drain_beat%0d got lane=%0d pc=%h seq=%0d", k, out_lane, out_pc, out_seq); else n_pass++;
         @(negedge clock);
      end
      out_ready = 1'b0;
      n_total++; if ({out_valid, count, out_seq} !== {1'b0, 5'd0, 32'd19})
         $display("FAIL drain_done got v=%b count=%0d seq=%0d exp 0 0 19", out_valid, count, out_seq); else n_pass++;
   endtask

   task automatic test_overflow();
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0; out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         drive(4'b1111, 32'h300 + 32'(c));
         @(negedge clock);
      end
      drive(4'b0011, 32'h303);
      @(negedge clock);
      n_total++; if (count !== 5'd14) $display("FAIL ovf_pre_count got %0d exp 14", count); else n_pass++;
      drive(4'b0111, 32'h304);
      @(negedge clock);
      drive(4'b0000, 32'h0);
      n_total++; if ({count, overflow, drop_cnt} !== {5'd14, 1'b1, 16'd3})
         $display("FAIL ovf_group_drop got count=%0d ovf=%b drop=%0d exp 14 1 3", count, overflow, drop_cnt); else n_pass++;
      drive(4'b0011, 32'h305);
      @(negedge clock);
      drive(4'b0000, 32'h0);
      n_total++; if ({count, stall, out_valid} !== {5'd16, 1'b1, 1'b1})
         $display("FAIL ovf_fit_accept got count=%0d stall=%b v=%b exp 16 1 1", count, stall, out_valid); else n_pass++;
   endtask

   task automatic test_full_same_cycle_deq();
      out_ready = 1'b1;
      drive(4'b0001, 32'h306);
      @(negedge clock);
      drive(4'b0000, 32'h0);
      out_ready = 1'b0;
      n_total++; if ({count, drop_cnt, out_seq} !== {5'd15, 16'd4, 32'd1})
         $display("FAIL full_deq got count=%0d drop=%0d seq=%0d exp 15 4 1", count, drop_cnt, out_seq); else n_pass++;
      n_total++; if ({out_pc, out_lane} !== {32'h300, 32'd1, 2'd1})
         $display("FAIL full_deq_head got pc=%h lane=%0d", out_pc, out_lane); else n_pass++;
   endtask

   task automatic test_enable_gate();
      enable = 1'b0;
      drive(4'b1111, 32'h307);
      @(negedge clock);
      drive(4'b0000, 32'h0);
      enable = 1'b1;
      n_total++; if ({count, drop_cnt, out_pc} !== {5'd15, 16'd4, 32'h300, 32'd1})
         $display("FAIL enable_gate got count=%0d drop=%0d pc=%h exp 15 4", count, drop_cnt, out_pc); else n_pass++;
   endtask

   task automatic test_reset_mid_burst();
      out_ready = 1'b1;
      repeat (8) @(negedge clock);
      out_ready = 1'b0;
      n_total++; if ({count, out_valid, overflow, out_seq} !== {5'd7, 1'b1, 1'b1, 32'd9})
         $display("FAIL mid_pre got count=%0d v=%b ovf=%b seq=%0d exp 7 1 1 9", count, out_valid, overflow, out_seq); else n_pass++;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      n_total++; if ({count, out_valid, out_seq, overflow, drop_cnt, stall} !== {5'd0, 1'b0, 32'd0, 1'b0, 16'd0, 1'b0})
         $display("FAIL mid_reset got count=%0d v=%b seq=%0d ovf=%b drop=%0d stall=%b", count, out_valid, out_seq, overflow, drop_cnt, stall); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_sparse_group();
      test_fill_and_drain();
      test_overflow();
      test_full_same_cycle_deq();
      test_enable_gate();
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
